// File: rtl/dnn_train_pkg.sv
// Shared types and sizing helpers for the training-run sequencer.
// Default sizes match the full training configuration; blocks recompute widths from their own parameters.
package dnn_train_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int width_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int CPC_DEF = 18;
  localparam int TC_DEF  = 10000;
  localparam int NE_DEF  = 10;
  localparam int CL_DEF  = 1000;

  localparam int CI_W_DEF  = width_of(CPC_DEF);
  localparam int SN_W_DEF  = width_of(CPC_DEF - 2);
  localparam int TC_W_DEF  = width_of(TC_DEF);
  localparam int EP_W_DEF  = width_of(NE_DEF + 1);
  localparam int RC_W_DEF  = width_of(CL_DEF + 1);
  localparam int TOT_W_DEF = width_of(NE_DEF * TC_DEF + 1);

endpackage

// File: rtl/accuracy_window.sv
// Sliding-window correct counter over the last `checklast` scored cases.
// Buffer starts cleared, so the running sum can never underflow.
module accuracy_window
  import dnn_train_pkg::*;
#(
  parameter  int checklast = CL_DEF,
  localparam int RC_W      = width_of(checklast + 1),
  localparam int PTR_W     = width_of(checklast)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            push,
  input  logic            bit_in,
  output logic [RC_W-1:0] recent
);

  logic [checklast-1:0] win_q, win_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [RC_W-1:0]      recent_q, recent_d;

  always_comb begin
    win_d    = win_q;
    ptr_d    = ptr_q;
    recent_d = recent_q;
    if (clear) begin
      win_d    = '0;
      ptr_d    = '0;
      recent_d = '0;
    end else if (push) begin
      recent_d     = recent_q - RC_W'(win_q[ptr_q]) + RC_W'(bit_in);
      win_d[ptr_q] = bit_in;
      ptr_d        = (ptr_q == PTR_W'(checklast - 1)) ? '0 : ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      win_q    <= '0;
      ptr_q    <= '0;
      recent_q <= '0;
    end else begin
      win_q    <= win_d;
      ptr_q    <= ptr_d;
      recent_q <= recent_d;
    end
  end

  assign recent = recent_q;

endmodule

// File: rtl/train_sequencer.sv
// Training-run controller: block-cycle, slice and case sequencing, epoch counting and per-case scoring.
//   state   | meaning
//   IDLE    | after reset, waiting for start
//   RUN     | presenting cases; hold freezes everything
//   DONE    | all epochs presented, results held until restart
module train_sequencer
  import dnn_train_pkg::*;
#(
  parameter  int cpc            = CPC_DEF,
  parameter  int training_cases = TC_DEF,
  parameter  int num_epochs     = NE_DEF,
  parameter  int checklast      = CL_DEF,
  localparam int CI_W  = width_of(cpc),
  localparam int SN_W  = width_of(cpc - 2),
  localparam int TC_W  = width_of(training_cases),
  localparam int EP_W  = width_of(num_epochs + 1),
  localparam int RC_W  = width_of(checklast + 1),
  localparam int TOT_W = width_of(num_epochs * training_cases + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             hold,
  input  logic             a_out_bit,
  input  logic             y_out_bit,
  output logic [CI_W-1:0]  cycle_index,
  output logic [SN_W-1:0]  sel_network,
  output logic [TC_W-1:0]  sel_tc,
  output logic [EP_W-1:0]  epoch,
  output logic             cycle_clk,
  output logic             busy,
  output logic             done,
  output logic             case_valid,
  output logic             case_correct,
  output logic [RC_W-1:0]  recent,
  output logic [TOT_W-1:0] total_correct
);

  localparam logic [CI_W-1:0] CI_LAST = CI_W'(cpc - 1);
  localparam logic [TC_W-1:0] TC_LAST = TC_W'(training_cases - 1);
  localparam logic [EP_W-1:0] EP_LAST = EP_W'(num_epochs);

  state_e           state_q, state_d;
  logic [CI_W-1:0]  cycle_q, cycle_d;
  logic [TC_W-1:0]  tc_q, tc_d;
  logic [EP_W-1:0]  epoch_q, epoch_d;
  logic [TOT_W-1:0] total_q, total_d;
  logic             mismatch_q, mismatch_d;
  logic             valid_q, valid_d;
  logic             correct_q, correct_d;
  logic             last_cyc, bit_ne, correct, win_clear, win_push;

  always_comb begin
    state_d    = state_q;
    cycle_d    = cycle_q;
    tc_d       = tc_q;
    epoch_d    = epoch_q;
    total_d    = total_q;
    mismatch_d = mismatch_q;
    valid_d    = 1'b0;
    correct_d  = correct_q;
    win_clear  = 1'b0;
    win_push   = 1'b0;
    bit_ne     = a_out_bit ^ y_out_bit;
    last_cyc   = (cycle_q == CI_LAST);
    correct    = ~(mismatch_q | bit_ne);

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d    = ST_RUN;
          cycle_d    = '0;
          tc_d       = '0;
          epoch_d    = EP_W'(1);
          total_d    = '0;
          mismatch_d = 1'b0;
          correct_d  = 1'b0;
          win_clear  = 1'b1;
        end
      end
      ST_RUN: begin
        if (hold) begin
          valid_d = valid_q;
        end else begin
          cycle_d = last_cyc ? '0 : cycle_q + CI_W'(1);
          // Cycles 0 and 1 are pipeline fill; only data slices are scored.
          if (cycle_q == '0)
            mismatch_d = 1'b0;
          else if (cycle_q >= CI_W'(2))
            mismatch_d = mismatch_q | bit_ne;
          if (last_cyc) begin
            valid_d   = 1'b1;
            correct_d = correct;
            win_push  = 1'b1;
            total_d   = total_q + TOT_W'(correct);
            if (tc_q == TC_LAST) begin
              tc_d = '0;
              if (epoch_q == EP_LAST)
                state_d = ST_DONE;
              else
                epoch_d = epoch_q + EP_W'(1);
            end else begin
              tc_d = tc_q + TC_W'(1);
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cycle_q    <= '0;
      tc_q       <= '0;
      epoch_q    <= '0;
      total_q    <= '0;
      mismatch_q <= 1'b0;
      valid_q    <= 1'b0;
      correct_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cycle_q    <= cycle_d;
      tc_q       <= tc_d;
      epoch_q    <= epoch_d;
      total_q    <= total_d;
      mismatch_q <= mismatch_d;
      valid_q    <= valid_d;
      correct_q  <= correct_d;
    end
  end

  accuracy_window #(.checklast(checklast)) u_window (
    .clk    (clk),
    .reset  (reset),
    .clear  (win_clear),
    .push   (win_push),
    .bit_in (correct),
    .recent (recent)
  );

  // Wraps in cycles 0 and 1 to the last two slices; downstream relies on that.
  assign sel_network   = SN_W'(cycle_q - CI_W'(2));
  assign cycle_index   = cycle_q;
  assign sel_tc        = tc_q;
  assign epoch         = epoch_q;
  assign cycle_clk     = (state_q == ST_RUN) && last_cyc;
  assign busy          = (state_q == ST_RUN);
  assign done          = (state_q == ST_DONE);
  assign case_valid    = valid_q;
  assign case_correct  = correct_q;
  assign total_correct = total_q;

endmodule

// File: tb/tb_train_sequencer.sv
// Table-driven bench for train_sequencer with a scoreboard of expected per-case scores.
module tb_train_sequencer;

  localparam int CPC = 6;
  localparam int TC  = 4;
  localparam int NE  = 2;
  localparam int CL  = 3;

  logic       clk = 1'b0;
  logic       reset, start, hold, a_out_bit, y_out_bit;
  logic [2:0] cycle_index;
  logic [1:0] sel_network, sel_tc, epoch, recent;
  logic [3:0] total_correct;
  logic       cycle_clk, busy, done, case_valid, case_correct;

  always #5 clk = ~clk;

  train_sequencer #(.cpc(CPC), .training_cases(TC), .num_epochs(NE), .checklast(CL)) dut (
    .clk(clk), .reset(reset), .start(start), .hold(hold),
    .a_out_bit(a_out_bit), .y_out_bit(y_out_bit),
    .cycle_index(cycle_index), .sel_network(sel_network), .sel_tc(sel_tc), .epoch(epoch),
    .cycle_clk(cycle_clk), .busy(busy), .done(done), .case_valid(case_valid),
    .case_correct(case_correct), .recent(recent), .total_correct(total_correct)
  );

  typedef struct {
    bit go;
    int mm;
    int hold_at;
    int rst_at;
    int start_at;
    bit exp_correct;
  } vec_t;

  typedef struct {
    bit correct;
    int recent;
    int total;
  } exp_t;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];
  bit   hist[$];
  int   exp_tc, exp_ep;
  vec_t vecs[$];
  int   sn_exp[6] = '{2, 3, 0, 1, 2, 3};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(bit go, int mm, int hold_at, int rst_at, int start_at, bit exp_correct);
    vec_t v;
    v.go = go; v.mm = mm; v.hold_at = hold_at; v.rst_at = rst_at;
    v.start_at = start_at; v.exp_correct = exp_correct;
    return v;
  endfunction

  always @(negedge clk) begin
    if (case_valid === 1'b1 && !hold) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL case_valid: got 1 expected 0 (no case pending, t=%0t)", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("case_correct", case_correct, e.correct);
        chk("recent", recent, e.recent);
        chk("total_correct", total_correct, e.total);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, " cycle_index"}, cycle_index, 0);
    chk({tag, " sel_tc"}, sel_tc, 0);
    chk({tag, " epoch"}, epoch, 0);
    chk({tag, " recent"}, recent, 0);
    chk({tag, " total_correct"}, total_correct, 0);
    chk({tag, " cycle_clk"}, cycle_clk, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " case_valid"}, case_valid, 0);
    chk({tag, " case_correct"}, case_correct, 0);
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    hist.delete();
    exp_tc = 0;
    exp_ep = 1;
    chk("start busy", busy, 1);
    chk("start done", done, 0);
    chk("start cycle_index", cycle_index, 0);
    chk("start epoch", epoch, 1);
    chk("start total_correct", total_correct, 0);
    chk("start recent", recent, 0);
  endtask

  task automatic run_case(input vec_t v);
    exp_t e;
    int   sum;
    int   n;
    chk("sel_tc", sel_tc, exp_tc);
    chk("epoch", epoch, exp_ep);
    for (int c = 0; c < CPC; c++) begin
      chk("cycle_index", cycle_index, c);
      chk("sel_network", sel_network, sn_exp[c]);
      chk("cycle_clk", cycle_clk, (c == CPC - 1));
      chk("busy", busy, 1);
      if (c == v.hold_at) begin
        hold = 1'b1;
        a_out_bit = 1'b1;
        y_out_bit = 1'b0;
        for (int h = 0; h < 7; h++) begin
          step();
          chk("hold cycle_index", cycle_index, c);
          chk("hold sel_network", sel_network, sn_exp[c]);
          chk("hold sel_tc", sel_tc, exp_tc);
          chk("hold epoch", epoch, exp_ep);
          chk("hold busy", busy, 1);
          chk("hold case_valid", case_valid, 0);
        end
        hold = 1'b0;
      end
      if (c == v.rst_at) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_all_zero("reset");
        return;
      end
      start = (c == v.start_at);
      a_out_bit = 1'($urandom_range(0, 1));
      y_out_bit = (c == v.mm) ? ~a_out_bit : a_out_bit;
      step();
      start = 1'b0;
    end
    hist.push_back(v.exp_correct);
    sum = 0;
    n = 0;
    for (int i = hist.size() - 1; i >= 0 && n < CL; i--) begin
      sum += int'(hist[i]);
      n++;
    end
    e.correct = v.exp_correct;
    e.recent  = sum;
    e.total   = 0;
    foreach (hist[i]) e.total += int'(hist[i]);
    sb.push_back(e);
    exp_tc++;
    if (exp_tc == TC) begin
      exp_tc = 0;
      if (exp_ep == NE) begin
        chk("final done", done, 1);
        chk("final busy", busy, 0);
        chk("final epoch", epoch, NE);
        chk("final sel_tc", sel_tc, 0);
        chk("final cycle_index", cycle_index, 0);
        chk("final case_valid", case_valid, 1);
        step();
        chk("done stays", done, 1);
        chk("done case_valid drops", case_valid, 0);
        chk("done cycle_clk", cycle_clk, 0);
      end else begin
        exp_ep++;
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; hold = 1'b0; a_out_bit = 1'b0; y_out_bit = 1'b0;
    exp_tc = 0; exp_ep = 0;

    // Run A: eight matching cases.
    vecs.push_back(mk(1, -1, -1, -1, -1, 1));
    for (int i = 0; i < 7; i++) vecs.push_back(mk(0, -1, -1, -1, -1, 1));
    // Run B from DONE: mismatches at various positions.
    vecs.push_back(mk(1, 5, -1, -1, -1, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0, -1, -1, -1, -1, 1));
    vecs.push_back(mk(0, 1, -1, -1, -1, 1));
    vecs.push_back(mk(0, 2, -1, -1, -1, 0));
    vecs.push_back(mk(0, 0, -1, -1, -1, 1));
    vecs.push_back(mk(0, 3, -1, -1, -1, 0));
    // Run C: hold, start in RUN, then reset at case 5 cycle 3.
    vecs.push_back(mk(1, -1, 2, -1, -1, 1));
    vecs.push_back(mk(0, -1, -1, -1, 3, 1));
    vecs.push_back(mk(0, 4, -1, -1, -1, 0));
    vecs.push_back(mk(0, -1, -1, -1, -1, 1));
    vecs.push_back(mk(0, -1, -1, -1, -1, 1));
    vecs.push_back(mk(0, -1, -1, 3, -1, 0));
    // Run D: restart from IDLE.
    vecs.push_back(mk(1, -1, -1, -1, -1, 1));
    vecs.push_back(mk(0, 5, -1, -1, -1, 0));

    repeat (3) step();
    reset = 1'b0;
    check_all_zero("post-reset");
    hold = 1'b1;
    step();
    hold = 1'b0;
    check_all_zero("idle hold");

    foreach (vecs[i]) begin
      if (vecs[i].go) do_start();
      run_case(vecs[i]);
    end

    repeat (2) step();
    chk("scoreboard drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
